store_buffer: RTL

Write queue between the store-data formatter and the data-memory port.
- Accepts one store per cycle: funct3, byte address, and right-justified zero-extended store data.
- Aligns the data onto the correct byte lanes and generates the 4-bit byte strobe.
- Queues the store in a small FIFO and drains entries to data memory with a valid/ready handshake.
- Flags loads whose word address hits a pending store, so the core can stall until the store drains.

---
 rtl/store_buffer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store write queue: formats store data onto byte lanes, queues entries in a
// small FIFO, drains them to data memory and flags loads that hit a pending word.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             storeValid,
    input  logic [2:0]       funct3,
    input  logic [31:0]      storeAddr,
    input  logic [31:0]      storeData,
    output logic             storeReady,
    output logic             storeErr,
    input  logic             loadCheck,
    input  logic [31:0]      loadAddr,
    output logic             loadConflict,
    output logic             memValid,
    input  logic             memReady,
    output logic [31:0]      memAddr,
    output logic [31:0]      memData,
    output logic [3:0]       memStrb,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W:0]   r_count;

    logic [29:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [3:0]       r_strb [DEPTH];

    logic [1:0]       w_off;
    logic [3:0]       w_strb;
    logic [31:0]      w_data;
    logic             w_bad;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_hit;

    assign w_off = storeAddr[1:0];

    // Lane replication: memory only writes the lanes enabled by the strobe.
    always_comb begin
        w_strb = 4'b0000;
        w_data = 32'h0;
        w_bad  = 1'b0;
        case (funct3)
            3'b000: begin
                w_strb = 4'b0001 << w_off;
                w_data = {4{storeData[7:0]}};
            end
            3'b001: begin
                w_bad  = w_off[0];
                w_strb = w_off[1] ? 4'b1100 : 4'b0011;
                w_data = {2{storeData[15:0]}};
            end
            3'b010: begin
                w_bad  = |w_off;
                w_strb = 4'b1111;
                w_data = storeData;
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign storeReady = (r_count != L_FULL);
    assign storeErr   = storeValid & w_bad;
    assign w_push     = storeValid & storeReady & ~w_bad;
    assign empty      = (r_count == '0);
    assign memValid   = ~empty;
    assign w_pop      = memValid & memReady;
    assign count      = r_count;

    assign memAddr = memValid ? {r_addr[r_rptr], 2'b00} : 32'h0;
    assign memData = memValid ? r_data[r_rptr] : 32'h0;
    assign memStrb = memValid ? r_strb[r_rptr] : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: it is only observed through slots inside the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= storeAddr[31:2];
            r_data[r_wptr] <= w_data;
            r_strb[r_wptr] <= w_strb;
        end
    end

    // A slot is live when its distance from the head is below the fill level.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PTR_W-1:0] w_dist;
            assign w_dist    = PTR_W'(gi) - r_rptr;
            assign w_hit[gi] = ({1'b0, w_dist} < r_count) &&
                               (r_addr[gi] == loadAddr[31:2]);
        end
    endgenerate

    assign loadConflict = loadCheck & (|w_hit);

endmodule
